operand_collector: RTL
======================

Name: operand_collector

Overview:
- Parametrised, registered successor to the calculator's combinational byte-steering stage.
- Captures NUM_OPS operands of WIDTH bits from one shared input bus into a packed operand bus.
- Tracks which operands are loaded and presents the full set to the ALU with a valid/ack handshake.
- Optional auto-advance mode fills operand slots in order without an external select.

Parameters:
- WIDTH, 8, bits per operand.
- NUM_OPS, 2, number of operand slots (>= 2).
- AUTO_ADV, 0, 1 = slot chosen by internal write pointer; 0 = slot chosen by op_sel.
- SEL_W, $clog2(NUM_OPS), width of op_sel and wr_ptr (derived; minimum 1).
- CNT_W, $clog2(NUM_OPS+1), width of loaded_cnt (derived).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  operand data.
- op_sel  in  SEL_W  target slot when AUTO_ADV=0; ignored when AUTO_ADV=1.
- load  in  1  write din into the target slot this cycle.
- clr  in  1  synchronous clear of all slots and handshake state.
- ops_ack  in  1  consumer has taken the operand set.
- ops_bus  out  NUM_OPS*WIDTH  slot i at bits [i*WIDTH +: WIDTH]; slot 0 in the LSBs.
- ops_valid  out  1  all slots loaded; set is stable.
- loaded_cnt  out  CNT_W  number of distinct slots loaded so far.
- load_err  out  1  one-cycle pulse on a rejected load.

Behaviour:
- Reset: ops_bus=0, ops_valid=0, loaded_cnt=0, load_err=0, loaded mask=0, wr_ptr=0, state=COLLECT.
- All outputs are registered.
- Priority: rst > clr > ops_ack > load.
- States: COLLECT, FULL.
- COLLECT, load=1:
  - Target slot = wr_ptr if AUTO_ADV=1, else op_sel.
  - Write din into the target slot and set its mask bit; the new value appears on ops_bus the next cycle.
  - Reloading an already-loaded slot overwrites its data; loaded_cnt does not change.
  - AUTO_ADV=1: wr_ptr increments after each accepted load and wraps from NUM_OPS-1 to 0.
  - op_sel >= NUM_OPS (AUTO_ADV=0 only): no write, load_err=1 next cycle.
- COLLECT -> FULL: on the edge where the mask becomes all ones; ops_valid=1 in the cycle after the completing load.
- FULL:
  - ops_valid held high and ops_bus frozen.
  - load is rejected and load_err pulses.
  - ops_ack=1: next cycle ops_valid=0, mask=0, loaded_cnt=0, wr_ptr=0, state=COLLECT.
  - ops_bus keeps its old values after ack until slots are overwritten.
  - ops_ack together with load in FULL: ack taken, load rejected (load_err=1).
- ops_ack in COLLECT: ignored.
- clr (any state): next cycle ops_bus=0, mask=0, loaded_cnt=0, wr_ptr=0, ops_valid=0, state=COLLECT; a load or ack in the same cycle is discarded with no load_err.
- rst mid-operation: identical to the reset values above; a partial operand set is discarded.
- load_err is high for exactly one cycle per rejected load; back-to-back rejects give a continuous high.

Test Plan:
- NUM_OPS=2, WIDTH=8, AUTO_ADV=0: load op_sel=1 din=0x12, then op_sel=0 din=0x34 -> ops_bus=0x1234; ops_valid rises 1 cycle after the 2nd load; loaded_cnt 1 then 2.
- Same config, load slot 0 with 0xAA then 0x55 -> ops_bus[7:0]=0x55, loaded_cnt stays 1, ops_valid stays 0.
- In FULL, load din=0xFF with ops_ack=1 -> load_err pulses 1 cycle, ops_valid=0 next cycle, ops_bus unchanged (0x1234), loaded_cnt=0.
- NUM_OPS=3, AUTO_ADV=1: load 0x01, 0x02, 0x03 -> ops_bus=0x030201, ops_valid=1; after ack, load 0x09 -> ops_bus=0x030209 (wr_ptr restarted at 0).
- NUM_OPS=3, AUTO_ADV=0: op_sel=3 with load -> load_err=1 for one cycle, ops_bus and loaded_cnt unchanged.
- After one slot loaded, assert clr together with load -> ops_bus=0, loaded_cnt=0, no load_err; repeat with rst instead of clr -> all outputs at reset values.

Source files
------------

// File: rtl/operand_collector.sv
// operand_collector: registered operand capture for the ALU front end.
// Operands arrive one at a time on a shared din bus and land in NUM_OPS
// slots. Once every slot has been written, the set is presented with
// ops_valid and stays frozen until the consumer acks it.

// One operand slot: a WIDTH-bit register cleared by rst/clr.
module operand_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  // Clear has priority over a write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (we)    q <= din;
  end

endmodule

module operand_collector #(
  parameter int WIDTH    = 8,
  parameter int NUM_OPS  = 2,
  parameter int AUTO_ADV = 0,
  parameter int SEL_W    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
  parameter int CNT_W    = $clog2(NUM_OPS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic [SEL_W-1:0]         op_sel,
  input  logic                     load,
  input  logic                     clr,
  input  logic                     ops_ack,
  output logic [NUM_OPS*WIDTH-1:0] ops_bus,
  output logic                     ops_valid,
  output logic [CNT_W-1:0]         loaded_cnt,
  output logic                     load_err
);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t                          state;
  logic [NUM_OPS-1:0]              mask;
  logic [NUM_OPS-1:0]              hit;
  logic [NUM_OPS-1:0]              we;
  logic [NUM_OPS-1:0][WIDTH-1:0]   slots;
  logic [SEL_W-1:0]                wr_ptr;
  logic [SEL_W-1:0]                tgt;
  logic                            sel_ok;
  logic                            acc;
  logic                            new_slot;
  logic                            set_done;

  // An out-of-range op_sel matches no slot, so sel_ok doubles as the range check.
  assign tgt      = (AUTO_ADV != 0) ? wr_ptr : op_sel;
  assign sel_ok   = |hit;
  assign acc      = load && !clr && (state == COLLECT) && sel_ok;
  assign new_slot = |(hit & ~mask);
  assign set_done = &(mask | hit);
  assign ops_bus  = slots;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_slot
    assign hit[i] = (tgt == SEL_W'(i));
    assign we[i]  = acc && hit[i];
    operand_slot #(.WIDTH(WIDTH)) u_slot (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .we  (we[i]),
      .din (din),
      .q   (slots[i])
    );
  end

  // Collect/full handshake: mask, count, write pointer, valid and error pulse.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state      <= COLLECT;
      mask       <= '0;
      loaded_cnt <= '0;
      wr_ptr     <= '0;
      ops_valid  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          // ops_ack has no meaning here; a load in the same cycle proceeds.
          load_err <= load && !sel_ok;
          if (acc) begin
            mask <= mask | hit;
            if (new_slot) loaded_cnt <= loaded_cnt + CNT_W'(1);
            if (AUTO_ADV != 0)
              wr_ptr <= (wr_ptr == SEL_W'(NUM_OPS - 1)) ? '0 : wr_ptr + SEL_W'(1);
            if (set_done) begin
              state     <= FULL;
              ops_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          // The set is frozen: every load is rejected, even alongside an ack.
          load_err <= load;
          if (ops_ack) begin
            state      <= COLLECT;
            ops_valid  <= 1'b0;
            mask       <= '0;
            loaded_cnt <= '0;
            wr_ptr     <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
